rtc_sw_ctrl: RTL and testbench
==============================

Name: rtc_sw_ctrl

Overview:
Stopwatch control block that sequences the six-digit BCD display datapath (rtc_seg_disp).
- Owns the run/pause/lap/clear state machine, the tick prescaler and the six-digit BCD time counter MM:SS.cc.
- Drives the 24-bit BCD word consumed by the seven-segment decoder.
- Inputs are single-cycle, already-debounced button pulses from the board interface logic.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
TICK_HZ, 100, count increment rate in Hz (one hundredth of a second)
DIV, CLK_HZ/TICK_HZ, derived prescaler terminal count, localparam, must be >= 2

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  synchronous, active-low reset
i_start_stop  input  1  one-cycle pulse, toggles run/pause
i_lap  input  1  one-cycle pulse, freeze/release displayed value
i_clear  input  1  one-cycle pulse, zero the count
o_count  output  24  BCD display word, [3:0] hundredths, [7:4] tenths, [11:8] sec ones, [15:12] sec tens, [19:16] min ones, [23:20] min tens
o_running  output  1  high in RUN or LAP
o_lap_active  output  1  high in LAP
o_wrap  output  1  one-cycle pulse on rollover 59:59.99 -> 00:00.00

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_rst_n. Reset has priority over all other inputs.
- Reset values:
  - state = IDLE
  - live count = 0, lap register = 0, prescaler = 0
  - o_count = 24'h000000, o_running = 0, o_lap_active = 0, o_wrap = 0
  - Reset asserted mid-run aborts everything on that edge.
- States: IDLE, RUN, PAUSED, LAP.
- Input priority when pulses coincide: i_clear > i_start_stop > i_lap. Only the highest-priority pulse acts; the others are dropped.
- Transitions:
  - IDLE:
    - start_stop -> RUN, prescaler zeroed.
    - clear -> IDLE, count zeroed.
    - lap ignored.
  - RUN:
    - start_stop -> PAUSED.
    - lap -> LAP, lap register <= live count, captured on the same edge.
    - clear ignored.
  - LAP:
    - Live count keeps advancing; o_count shows the lap register.
    - lap -> RUN.
    - start_stop -> PAUSED, display returns to live count.
    - clear -> RUN, lap released without zeroing the count.
  - PAUSED:
    - start_stop -> RUN, prescaler resumes from its held value.
    - clear -> IDLE, count and prescaler zeroed.
    - lap ignored.
- Prescaler:
  - Counts 0..DIV-1 only in RUN and LAP; held in PAUSED and IDLE.
  - tick = (prescaler == DIV-1) while counting.
  - Count increments on the edge where tick is true; o_count reflects it one cycle later, since it is a registered output.
- BCD arithmetic, per digit, ripple-carry within a single cycle:
  - Hundredths, tenths, sec ones and min ones wrap at 9.
  - Sec tens and min tens wrap at 5.
  - A carry into a digit occurs only when all lower digits wrap.
- Rollover from 59:59.99:
  - Next tick gives 00:00.00.
  - o_wrap is high for exactly the cycle after that edge.
  - State is unchanged.
- o_count is registered: lap register when in LAP, live count otherwise.
- Digit values 0xA–0xF are never produced.

Optional Feature:
RTC_SW_SATURATE_EN
- Defined:
  - Count saturates at 24'h595999 on the tick that would roll over.
  - o_wrap pulses once on the tick that reaches saturation.
  - Further ticks are ignored. State stays RUN/LAP until the user stops.
- Undefined: wrap-around behaviour as specified above.

Test Plan:
(All tests use CLK_HZ=10, TICK_HZ=1, so DIV=10.)
- Reset, then 20 idle cycles -> o_count=24'h000000, o_running=0, o_lap_active=0, o_wrap=0 throughout.
- start_stop, then run 10 ticks -> o_count=24'h000010. After 100 ticks -> 24'h000100. After 6000 ticks -> 24'h010000. Digits never exceed 9/5.
- Run 15 ticks, lap, run 7 more ticks -> o_count holds 24'h000015, o_lap_active=1. Lap again -> o_count=24'h000022 next cycle.
- Run 5 ticks, start_stop, wait 50 cycles -> o_count stays 24'h000005. Clear -> IDLE, 24'h000000. Clear pulsed during RUN -> ignored.
- Drive clear and start_stop on the same cycle in PAUSED -> IDLE with zeroed count, no RUN entry.
- Force count to 24'h595999 via ticks, one more tick -> o_count=24'h000000 with o_wrap high for 1 cycle. With RTC_SW_SATURATE_EN -> stays 24'h595999.

Source files
------------

// File: rtl/rtc_sw_ctrl.sv
// rtl/rtc_sw_ctrl.sv - stopwatch run/pause/lap/clear control with prescaler and MM:SS.cc BCD counter
// Optional: define RTC_SW_SATURATE_EN to hold at 59:59.99 instead of wrapping to zero.
module rtc_sw_ctrl #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start_stop,
    input  logic        i_lap,
    input  logic        i_clear,
    output logic [23:0] o_count,
    output logic        o_running,
    output logic        o_lap_active,
    output logic        o_wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] TERM      = PW'(DIV - 1);
    localparam logic [23:0]   MAX_COUNT = 24'h595999;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, LAP} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [23:0]   live, live_nxt, lap_q, lap_nxt, inc;
    logic          carry, counting, tick, wrap_nxt;
    logic          do_clear, do_ss, do_lap;

    // Ripple BCD increment; carry survives only while every lower digit wraps.
    always_comb begin
        inc   = live;
        carry = 1'b1;
        for (int d = 0; d < 6; d++) begin
            if (carry) begin
                if (live[d*4 +: 4] >= ((d == 3 || d == 5) ? 4'd5 : 4'd9)) begin
                    inc[d*4 +: 4] = 4'd0;
                end else begin
                    inc[d*4 +: 4] = live[d*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        live_nxt  = live;
        lap_nxt   = lap_q;
        wrap_nxt  = 1'b0;
        counting  = (state == RUN) || (state == LAP);
        tick      = counting && (presc == TERM);
        do_clear  = i_clear;
        do_ss     = i_start_stop && !i_clear;
        do_lap    = i_lap && !i_start_stop && !i_clear;

        if (counting) presc_nxt = tick ? '0 : presc + 1'b1;
        if (tick) begin
`ifdef RTC_SW_SATURATE_EN
            if (live != MAX_COUNT) begin
                live_nxt = inc;
                wrap_nxt = (inc == MAX_COUNT);
            end
`else
            live_nxt = inc;
            wrap_nxt = carry;
`endif
        end

        case (state)
            IDLE: begin
                if (do_clear) live_nxt = '0;
                else if (do_ss) begin
                    state_nxt = RUN;
                    presc_nxt = '0;
                end
            end
            RUN: begin
                if (do_ss) state_nxt = PAUSED;
                else if (do_lap) begin
                    state_nxt = LAP;
                    lap_nxt   = live;
                end
            end
            LAP: begin
                // Clear in LAP only releases the frozen display.
                if (do_clear || do_lap) state_nxt = RUN;
                else if (do_ss) state_nxt = PAUSED;
            end
            PAUSED: begin
                if (do_clear) begin
                    state_nxt = IDLE;
                    live_nxt  = '0;
                    presc_nxt = '0;
                end else if (do_ss) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            presc   <= '0;
            live    <= '0;
            lap_q   <= '0;
            o_count <= '0;
            o_wrap  <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            live    <= live_nxt;
            lap_q   <= lap_nxt;
            o_count <= (state == LAP) ? lap_q : live;
            o_wrap  <= wrap_nxt;
        end
    end

    assign o_running    = (state == RUN) || (state == LAP);
    assign o_lap_active = (state == LAP);

endmodule

// File: tb/tb_rtc_sw_ctrl.sv
// tb/tb_rtc_sw_ctrl.sv - randomized self-checking bench for rtc_sw_ctrl against a hundredths-based model
module tb_rtc_sw_ctrl;

    localparam int CLK_HZ  = 10;
    localparam int TICK_HZ = 1;
    localparam int DIV     = 10;
    localparam int MAXV    = 359999;

    typedef enum {M_IDLE, M_RUN, M_PAUSED, M_LAP} mode_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] count;
    logic        running, lap_active, wrap;

    int          checks = 0;
    int          errors = 0;

    mode_t       m_mode = M_IDLE;
    int          m_live = 0;
    int          m_lap = 0;
    int          m_pre = 0;
    logic [23:0] e_count = '0;
    logic        e_wrap = 1'b0;

    always #5 clk = ~clk;

    rtc_sw_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start_stop(start_stop),
        .i_lap       (lap),
        .i_clear     (clear),
        .o_count     (count),
        .o_running   (running),
        .o_lap_active(lap_active),
        .o_wrap      (wrap)
    );

    function automatic logic [23:0] to_bcd(input int v);
        int cs = v % 100;
        int s  = (v / 100) % 60;
        int m  = v / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    function automatic logic [26:0] exp_vec();
        return {e_count, (m_mode == M_RUN) || (m_mode == M_LAP), m_mode == M_LAP, e_wrap};
    endfunction

    task automatic model_edge(input logic ss, input logic lp, input logic cl);
        bit counting, tick;
        int old;
        if (!rst_n) begin
            m_mode = M_IDLE; m_live = 0; m_lap = 0; m_pre = 0; e_count = '0; e_wrap = 1'b0;
            return;
        end
        old      = m_live;
        e_count  = (m_mode == M_LAP) ? to_bcd(m_lap) : to_bcd(m_live);
        e_wrap   = 1'b0;
        counting = (m_mode == M_RUN) || (m_mode == M_LAP);
        tick     = counting && (m_pre == DIV - 1);
        if (counting) m_pre = (m_pre + 1) % DIV;
        if (tick) begin
`ifdef RTC_SW_SATURATE_EN
            if (old < MAXV) begin
                m_live = old + 1;
                e_wrap = (m_live == MAXV);
            end
`else
            m_live = (old + 1) % (MAXV + 1);
            e_wrap = (m_live == 0);
`endif
        end
        if (cl) begin
            case (m_mode)
                M_IDLE:   m_live = 0;
                M_PAUSED: begin m_mode = M_IDLE; m_live = 0; m_pre = 0; end
                M_LAP:    m_mode = M_RUN;
                default:  ;
            endcase
        end else if (ss) begin
            case (m_mode)
                M_IDLE:   begin m_mode = M_RUN; m_pre = 0; end
                M_PAUSED: m_mode = M_RUN;
                default:  m_mode = M_PAUSED;
            endcase
        end else if (lp) begin
            if (m_mode == M_RUN) begin m_mode = M_LAP; m_lap = old; end
            else if (m_mode == M_LAP) m_mode = M_RUN;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic ss, input logic lp, input logic cl);
        start_stop = ss; lap = lp; clear = cl;
        @(posedge clk);
        model_edge(ss, lp, cl);
        #1;
        start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic poke(input int v);
        dut.live = to_bcd(v);
        m_live   = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if ({count, running, lap_active, wrap} !== 27'h0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h/%b%b%b want=000000/000", i, count, running, lap_active, wrap);
            end
        end
    endtask

    task automatic test_run();
        logic [23:0] want;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 60001; i++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if ({count, running, lap_active, wrap} !== exp_vec()) begin
                errors++;
                if (errors < 30) $display("FAIL run_model i=%0d got=%h/%b%b%b want=%h", i, count, running, lap_active, wrap, exp_vec());
            end
            for (int d = 0; d < 6; d++) begin
                if (count[d*4 +: 4] > ((d == 3 || d == 5) ? 4'd5 : 4'd9)) begin
                    checks++; errors++;
                    if (errors < 30) $display("FAIL run_digit_range i=%0d d=%0d got=%h", i, d, count);
                end
            end
            if (i == 101 || i == 1001 || i == 60001) begin
                want = (i == 101) ? 24'h000010 : (i == 1001) ? 24'h000100 : 24'h010000;
                checks++;
                if (count !== want) begin
                    errors++;
                    $display("FAIL run_value i=%0d got=%h want=%h", i, count, want);
                end
            end
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_lap();
        step(1'b1, 1'b0, 1'b0);
        repeat (150) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 70; i++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if ({count, running, lap_active, wrap} !== exp_vec()) begin
                errors++;
                $display("FAIL lap_model i=%0d got=%h/%b%b%b want=%h", i, count, running, lap_active, wrap, exp_vec());
            end
        end
        checks++;
        if (count !== 24'h000015 || lap_active !== 1'b1) begin
            errors++;
            $display("FAIL lap_hold got=%h/%b want=000015/1", count, lap_active);
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 24'h000022 || lap_active !== 1'b0) begin
            errors++;
            $display("FAIL lap_release got=%h/%b want=000022/0", count, lap_active);
        end
        // LAP -> clear -> RUN (no zeroing), LAP -> start_stop -> PAUSED.
        step(1'b0, 1'b1, 1'b0);
        repeat (23) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({count, running, lap_active, wrap} !== exp_vec() || lap_active !== 1'b0 || count === 24'h0) begin
            errors++;
            $display("FAIL lap_clear got=%h/%b%b want=%h", count, running, lap_active, exp_vec());
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({count, running, lap_active, wrap} !== exp_vec() || running !== 1'b0) begin
            errors++;
            $display("FAIL lap_stop got=%h/%b%b want=%h", count, running, lap_active, exp_vec());
        end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_pause_clear();
        step(1'b1, 1'b0, 1'b0);
        repeat (50) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (50) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 24'h000005 || running !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold got=%h/%b want=000005/0", count, running);
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 24'h000000 || running !== 1'b0) begin
            errors++;
            $display("FAIL pause_clear got=%h/%b want=000000/0", count, running);
        end
        step(1'b1, 1'b0, 1'b0);
        repeat (30) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (20) step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({count, running, lap_active, wrap} !== exp_vec() || count !== 24'h000005) begin
            errors++;
            $display("FAIL run_clear_ignored got=%h/%b want=%h", count, running, exp_vec());
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 24'h000000 || running !== 1'b0 || m_mode != M_IDLE) begin
            errors++;
            $display("FAIL clear_over_start got=%h/%b want=000000/0", count, running);
        end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        poke(359990);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 140; i++) begin
            step(1'b0, 1'b0, 1'b0);
            pulses += int'(wrap);
            checks++;
            if ({count, running, lap_active, wrap} !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_model i=%0d got=%h/%b%b%b want=%h", i, count, running, lap_active, wrap, exp_vec());
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL wrap_pulses got=%0d want=1", pulses);
        end
        checks++;
`ifdef RTC_SW_SATURATE_EN
        if (count !== 24'h595999) begin
            errors++;
            $display("FAIL wrap_final got=%h want=595999", count);
        end
`else
        if (count !== 24'h000004) begin
            errors++;
            $display("FAIL wrap_final got=%h want=000004", count);
        end
`endif
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random_carries();
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
            poke((k == 0) ? 95999 : (k == 1) ? 5999 : $urandom_range(0, MAXV));
            step(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 40; i++) begin
                step(1'b0, 1'b0, 1'b0);
                checks++;
                if ({count, running, lap_active, wrap} !== exp_vec()) begin
                    errors++;
                    if (errors < 30) $display("FAIL carry_model k=%0d i=%0d got=%h want=%h", k, i, count, exp_vec());
                end
            end
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random_pulses();
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            step($urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 13) == 0);
            rst_n = 1'b1;
            checks++;
            if ({count, running, lap_active, wrap} !== exp_vec()) begin
                errors++;
                if (errors < 30) $display("FAIL random_model i=%0d got=%h/%b%b%b want=%h", i, count, running, lap_active, wrap, exp_vec());
            end
        end
    endtask

    task automatic test_reset_midrun();
        step(1'b1, 1'b0, 1'b0);
        repeat (37) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        checks++;
        if ({count, running, lap_active, wrap} !== 27'h0) begin
            errors++;
            $display("FAIL reset_midrun got=%h/%b%b%b want=000000/000", count, running, lap_active, wrap);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_run();
        test_lap();
        test_pause_clear();
        test_wrap();
        test_random_carries();
        test_random_pulses();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
